// File: rtl/gpio_in_conditioner.sv
// Purpose: synchronise and debounce raw board inputs, flag edges, keep sticky per-bit events and an irq.
// Latency: a stable new pin level reaches db_o on edge DB_CYCLES+2; rise/fall pulse with it; ev_o one edge later.
// Backpressure: none; free-running input conditioner, irq_o is combinational from ev_o and ie_i.
module gpio_in_conditioner #(
  parameter int WIDTH     = 12,
  parameter int DB_CYCLES = 250000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] clr_i,
  input  logic [WIDTH-1:0] ie_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] ev_o,
  output logic             irq_o
);

  // Counter is wide enough to hold DB_CYCLES; the terminal count is DB_CYCLES-1
  // because the edge that reaches it is also the edge that accepts the new level.
  localparam int              CW      = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_ev;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_flip;

  assign w_diff = r_s2 ^ r_db;

  // Two-flop synchroniser; only r_s2 is used past this point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pin_i;
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_flip[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);

    // Per-bit stability counter: any agreement with db_o restarts the count,
    // so a short glitch leaves nothing behind.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt[i] <= '0;
      end else if (!w_diff[i] || w_flip[i]) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // Accept the new level and emit the matching edge pulse on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_db   <= r_db ^ w_flip;
      r_rise <= w_flip & r_s2;
      r_fall <= w_flip & ~r_s2;
    end
  end

  // Sticky events: a new edge pulse overrides a coincident clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ev <= '0;
    end else begin
      r_ev <= (r_ev & ~clr_i) | r_rise | r_fall;
    end
  end

  assign db_o   = r_db;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign ev_o   = r_ev;
  assign irq_o  = |(r_ev & ie_i);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Purpose: directed check of the GPIO input conditioner (DB_CYCLES=4 and DB_CYCLES=1 instances).
// Latency: expectations counted in edges from the first edge that samples a new pin level.
// Backpressure: none; inputs change 1 time unit after a rising edge, outputs sampled there too.
module tb_gpio_in_conditioner;

  localparam int W = 12;

  logic         clk;
  logic         rst;
  logic [W-1:0] pin, clr, ie;
  logic [W-1:0] db, rise, fall, ev;
  logic         irq;
  logic [W-1:0] pin1, clr1, ie1;
  logic [W-1:0] db1, rise1, fall1, ev1;
  logic         irq1;

  int n_cmp;
  int n_bad;

  gpio_in_conditioner #(.WIDTH(W), .DB_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .clr_i(clr), .ie_i(ie),
    .db_o(db), .rise_o(rise), .fall_o(fall), .ev_o(ev), .irq_o(irq)
  );

  gpio_in_conditioner #(.WIDTH(W), .DB_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .pin_i(pin1), .clr_i(clr1), .ie_i(ie1),
    .db_o(db1), .rise_o(rise1), .fall_o(fall1), .ev_o(ev1), .irq_o(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rcnt, redge;
  logic [W-1:0] acc;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; pin = '0; clr = '0; ie = '0;
    pin1 = '0; clr1 = '0; ie1 = '0;
    tick(); tick();
    check_eq("rst_db",   32'(db),   32'h0);
    check_eq("rst_rise", 32'(rise), 32'h0);
    check_eq("rst_ev",   32'(ev),   32'h0);
    check_eq("rst_irq",  32'(irq),  32'h0);
    rst = 1'b0;
    tick();

    // Step on bit 0: db from edge 6, rise only at edge 6, ev from edge 7.
    pin[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_eq($sformatf("step_db_e%0d", e),   32'(db),   (e >= 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("step_rise_e%0d", e), 32'(rise), (e == 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("step_ev_e%0d", e),   32'(ev),   (e >= 7) ? 32'h1 : 32'h0);
    end
    check_eq("step_fall", 32'(fall), 32'h0);
    // Clear ev[0]; clr on bit 5 (ev=0) is harmless.
    clr = 12'h021;
    tick();
    clr = '0;
    check_eq("clr_ev0", 32'(ev), 32'h0);
    check_eq("clr_db_kept", 32'(db), 32'h1);

    // Glitch on bit 3, twice: a leftover count would make the second one flip.
    acc = '0;
    for (int g = 0; g < 2; g++) begin
      pin[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); acc = acc | db | rise | ev; end
      pin[3] = 1'b0;
      for (int k = 0; k < 9; k++) begin tick(); acc = acc | db | rise | ev; end
    end
    check_eq("glitch_bit3", 32'(acc[3]), 32'h0);
    check_eq("glitch_db", 32'(db), 32'h1);

    // Bounce on bit 8: 2-cycle segments never qualify; final hold rises at edge 6.
    rcnt = 0;
    for (int k = 0; k < 20; k++) begin
      pin[8] = (((k / 2) % 2) == 0);
      tick();
      if (rise[8]) rcnt++;
    end
    check_eq("bounce_no_rise", 32'(rcnt), 32'h0);
    check_eq("bounce_db", 32'(db[8]), 32'h0);
    pin[8] = 1'b1;
    redge = 0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (rise[8]) begin rcnt++; redge = e; end
    end
    check_eq("bounce_rise_cnt", 32'(rcnt), 32'h1);
    check_eq("bounce_rise_edge", 32'(redge), 32'h6);
    // Release bit 8: fall at edge 6, never a rise.
    pin[8] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_eq($sformatf("fall8_e%0d", e), 32'(fall[8]), (e == 6) ? 32'h1 : 32'h0);
      check_eq($sformatf("fall8_rise_e%0d", e), 32'(rise[8]), 32'h0);
    end

    // Events and irq on bit 2.
    pin[2] = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    check_eq("ev2_rise", 32'(rise[2]), 32'h1);
    ie = 12'h004;
    check_eq("irq_before_ev", 32'(irq), 32'h0);
    tick();
    check_eq("ev2_set", 32'(ev[2]), 32'h1);
    check_eq("irq_set", 32'(irq), 32'h1);
    clr[2] = 1'b1;
    tick();
    clr = '0;
    check_eq("ev2_clr", 32'(ev[2]), 32'h0);
    check_eq("irq_clr", 32'(irq), 32'h0);
    check_eq("ev8_indep", 32'(ev[8]), 32'h1);
    pin[2] = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    check_eq("ev2_fall_set", 32'(ev[2]), 32'h1);
    clr[2] = 1'b1;
    tick();
    clr = '0;
    check_eq("ev2_clr2", 32'(ev[2]), 32'h0);
    pin[2] = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    check_eq("coinc_rise", 32'(rise[2]), 32'h1);
    clr[2] = 1'b1;
    tick();
    clr = '0;
    check_eq("coinc_set_wins", 32'(ev[2]), 32'h1);
    check_eq("coinc_irq", 32'(irq), 32'h1);
    tick();
    check_eq("coinc_ev_hold", 32'(ev[2]), 32'h1);

    // Reset mid-count with all pins high; clr/ie ignored during reset.
    pin = 12'hFFF;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1; ie = 12'hFFF; clr = 12'hFFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq($sformatf("rst_mid_db%0d", k),   32'(db),   32'h0);
      check_eq($sformatf("rst_mid_rise%0d", k), 32'(rise), 32'h0);
      check_eq($sformatf("rst_mid_fall%0d", k), 32'(fall), 32'h0);
      check_eq($sformatf("rst_mid_ev%0d", k),   32'(ev),   32'h0);
      check_eq($sformatf("rst_mid_irq%0d", k),  32'(irq),  32'h0);
    end
    rst = 1'b0; clr = '0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_eq($sformatf("post_rst_rise_e%0d", e), 32'(rise), (e == 6) ? 32'hFFF : 32'h0);
      check_eq($sformatf("post_rst_db_e%0d", e),   32'(db),   (e >= 6) ? 32'hFFF : 32'h0);
      check_eq($sformatf("post_rst_fall_e%0d", e), 32'(fall), 32'h0);
      check_eq($sformatf("post_rst_irq_e%0d", e),  32'(irq),  (e >= 7) ? 32'h1 : 32'h0);
    end
    check_eq("post_rst_ev", 32'(ev), 32'hFFF);

    // DB_CYCLES=1: a one-cycle pin pulse flips db for exactly one cycle.
    pin1[0] = 1'b1;
    tick();
    pin1[0] = 1'b0;
    tick();
    check_eq("db1_e2", 32'(db1), 32'h0);
    tick();
    check_eq("db1_e3_db",   32'(db1),   32'h1);
    check_eq("db1_e3_rise", 32'(rise1), 32'h1);
    check_eq("db1_e3_fall", 32'(fall1), 32'h0);
    tick();
    check_eq("db1_e4_db",   32'(db1),   32'h0);
    check_eq("db1_e4_rise", 32'(rise1), 32'h0);
    check_eq("db1_e4_fall", 32'(fall1), 32'h1);
    tick();
    check_eq("db1_e5_fall", 32'(fall1), 32'h0);
    check_eq("db1_e5_ev",   32'(ev1),   32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 12; number of conditioned inputs (8 switches + 4 buttons on the board top).
REQ-002 SHALL have parameter DB_CYCLES, default 250000; consecutive stable cycles required to accept a new level; legal range 1..2^24-1.
REQ-003 SHALL have port clk_i, input, 1; single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port pin_i, input, WIDTH; raw asynchronous board inputs.
REQ-006 SHALL have port clr_i, input, WIDTH; one-cycle per-bit clear of the event register.
REQ-007 SHALL have port ie_i, input, WIDTH; per-bit interrupt enable.
REQ-008 SHALL have port db_o, output, WIDTH; debounced level; drives the SoC gpio_bi field.
REQ-009 SHALL have port rise_o, output, WIDTH; one-cycle pulse on a debounced 0->1 transition.
REQ-010 SHALL have port fall_o, output, WIDTH; one-cycle pulse on a debounced 1->0 transition.
REQ-011 SHALL have port ev_o, output, WIDTH; sticky per-bit event flags.
REQ-012 SHALL have port irq_o, output, 1; OR of (ev_o AND ie_i).

Function
REQ-013 Each bit SHALL pass through a 2-flop synchronizer (s1, s2); s2 is the only value used downstream.
REQ-014 Each bit SHALL own a counter of width clog2(DB_CYCLES+1).
REQ-015 When s2 equals db_o, the counter SHALL be cleared to 0.
REQ-016 When s2 differs from db_o and the counter is below DB_CYCLES-1, the counter SHALL increment by 1.
REQ-017 When s2 differs from db_o and the counter equals DB_CYCLES-1, db_o SHALL take s2 and the counter SHALL clear on the same edge.
REQ-018 Latency: a pin level held stable SHALL appear on db_o at edge DB_CYCLES+2, counting the first clk_i edge that samples the new level as edge 1.
REQ-019 A mismatch lasting fewer than DB_CYCLES cycles at s2 SHALL leave db_o unchanged and SHALL clear the counter.
REQ-020 With DB_CYCLES=1, a single mismatching s2 cycle SHALL flip db_o; the counter SHALL never leave 0.
REQ-021 rise_o[i] and fall_o[i] SHALL be registered and asserted for exactly one cycle, coincident with the first cycle db_o[i] shows the new value.
REQ-022 rise_o[i] and fall_o[i] SHALL never both be asserted; back-to-back pulses on one bit SHALL be separated by at least DB_CYCLES cycles.
REQ-023 ev_o[i] SHALL set on the edge following assertion of rise_o[i] or fall_o[i], and SHALL clear on the edge following clr_i[i]=1.
REQ-024 When set and clear coincide on the same bit in the same cycle, set SHALL win.
REQ-025 clr_i on a bit with ev_o=0 SHALL have no effect; bits SHALL be independent.
REQ-026 irq_o SHALL be combinational from ev_o and ie_i, with no added latency.

Reset
REQ-027 While rst_i=1 at an edge: s1, s2, db_o, counters, rise_o, fall_o, and ev_o SHALL all be 0; irq_o SHALL therefore be 0.
REQ-028 Reset asserted mid-count SHALL discard the partial count; after release a pin held at 1 SHALL reach db_o per REQ-018 timing, measured from the first post-reset edge, and SHALL produce a rise_o pulse.
REQ-029 clr_i and ie_i SHALL be ignored while rst_i=1.

Verification (WIDTH=12, DB_CYCLES=4)
REQ-030 Step test: pin_i[0] 0->1 held, first sampling edge = 1 -> db_o[0]=1 from edge 6; rise_o[0]=1 for that cycle only; ev_o[0]=1 from edge 7.
REQ-031 Glitch test: pin_i[3]=1 for 3 cycles then 0 -> db_o, rise_o, and ev_o stay 0; bit-3 counter returns to 0.
REQ-032 Bounce test: pin_i[8] toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one rise_o[8] pulse, 6 edges after the final toggle's first sampling edge.
REQ-033 Event/irq test: ev_o[2]=1, ie_i=12'h004 -> irq_o=1; clr_i[2] pulse -> ev_o[2]=0 and irq_o=0 next cycle; clr_i[2] coincident with rise_o[2] -> ev_o[2] stays 1.
REQ-034 Reset test: rst_i pulsed with counter=2 and pin_i=12'hFFF -> all outputs 0 during reset; rise_o=12'hFFF asserted 6 edges after release; fall_o stays 0.
REQ-035 DB_CYCLES=1 instance: single-cycle pin pulse wide enough to be captured by s2 -> db_o follows, producing one rise_o pulse and one fall_o pulse.
